// File: rtl/rc_pwm_mode_detector.sv
// rc_pwm_mode_detector: measures RC servo pulses on CLOCK_50, validates them
// against range limits and derives a debounced mode request with hysteresis,
// N-frame confirmation and a loss-of-signal failsafe to manual.
module rc_pwm_mode_detector #(
    parameter int unsigned CLKS_PER_US = 50,
    parameter int unsigned MIN_US      = 900,
    parameter int unsigned MAX_US      = 2100,
    parameter int unsigned ON_US       = 1600,
    parameter int unsigned OFF_US      = 1400,
    parameter int unsigned CONFIRM     = 3,
    parameter int unsigned TIMEOUT_US  = 50000
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        PWM_IN,
    output logic        MODE_REQ,
    output logic        SIGNAL_OK,
    output logic [11:0] PULSE_WIDTH,
    output logic        PULSE_STROBE,
    output logic        PULSE_ERR
);
    localparam int unsigned PRESC_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int unsigned LOSS_W  = (TIMEOUT_US > 0) ? $clog2(TIMEOUT_US + 1) : 1;
    localparam int unsigned RUN_W   = $clog2(CONFIRM + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST   = PRESC_W'(CLKS_PER_US - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LIMIT   = LOSS_W'(TIMEOUT_US);
    localparam logic [LOSS_W-1:0]  LOSS_LAST    = LOSS_W'(TIMEOUT_US - 1);
    localparam logic [RUN_W-1:0]   RUN_FULL     = RUN_W'(CONFIRM);
    localparam logic [RUN_W-1:0]   CONFIRM_LAST = RUN_W'(CONFIRM - 1);
    localparam logic [11:0]        MIN_W        = 12'(MIN_US);
    localparam logic [11:0]        MAX_W        = 12'(MAX_US);
    localparam logic [11:0]        ON_W         = 12'(ON_US);
    localparam logic [11:0]        OFF_W        = 12'(OFF_US);

    typedef enum logic [1:0] {ARM, LOW, HIGH, EVAL} state_t;

    state_t               state, next_state;
    logic                 sync1, sync2, sync3;
    logic                 rise, fall;
    logic [PRESC_W-1:0]   presc;
    logic [11:0]          width_cnt;
    logic [PRESC_W-1:0]   loss_presc;
    logic [LOSS_W-1:0]    loss_cnt;
    logic                 loss_tick, timeout_fire;
    logic [RUN_W-1:0]     valid_run, valid_run_next;
    logic [RUN_W-1:0]     confirm_cnt, confirm_next;
    logic                 signal_ok_next, mode_req_next;
    logic                 in_range, eval_valid, eval_err;
    logic                 cand_on, cand_off;

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= PWM_IN;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;
    assign fall = ~sync2 & sync3;

    // FSM state register.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) state <= ARM;
        else       state <= next_state;
    end

    // FSM next state: ARM discards any pulse already in progress at start-up.
    always_comb begin
        next_state = state;
        case (state)
            ARM:     if (!sync2) next_state = LOW;
            LOW:     if (rise)   next_state = HIGH;
            HIGH:    if (fall)   next_state = EVAL;
            EVAL:    next_state = LOW;
            default: next_state = ARM;
        endcase
    end

    // Pulse width measurement in whole microseconds, saturating at 4095.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            presc     <= '0;
            width_cnt <= '0;
        end else if (state == LOW && rise) begin
            presc     <= '0;
            width_cnt <= '0;
        end else if (state == HIGH) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                if (width_cnt != '1) width_cnt <= width_cnt + 12'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign in_range     = (width_cnt >= MIN_W) && (width_cnt <= MAX_W);
    assign eval_valid   = (state == EVAL) && in_range;
    assign eval_err     = (state == EVAL) && !in_range;
    assign loss_tick    = (loss_presc == PRESC_LAST);
    assign timeout_fire = loss_tick && (loss_cnt == LOSS_LAST);

    // Loss timer: free-running us count since the last valid pulse, holds at the limit.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            loss_presc <= '0;
            loss_cnt   <= '0;
        end else if (eval_valid) begin
            loss_presc <= '0;
            loss_cnt   <= '0;
        end else begin
            loss_presc <= loss_tick ? '0 : loss_presc + 1'b1;
            if (loss_tick && loss_cnt != LOSS_LIMIT) loss_cnt <= loss_cnt + 1'b1;
        end
    end

    // Frame decision; a valid pulse takes priority over a simultaneous timeout.
    always_comb begin
        valid_run_next = valid_run;
        confirm_next   = confirm_cnt;
        signal_ok_next = SIGNAL_OK;
        mode_req_next  = MODE_REQ;
        cand_on        = (width_cnt >= ON_W);
        cand_off       = (width_cnt <= OFF_W);
        if (eval_valid) begin
            if (valid_run != RUN_FULL) valid_run_next = valid_run + 1'b1;
            if (valid_run_next == RUN_FULL) signal_ok_next = 1'b1;
            if ((!cand_on && !cand_off) || (cand_on == MODE_REQ)) begin
                confirm_next = '0;
            end else if (confirm_cnt == CONFIRM_LAST) begin
                confirm_next = '0;
                if (MODE_REQ || signal_ok_next) mode_req_next = ~MODE_REQ;
            end else begin
                confirm_next = confirm_cnt + 1'b1;
            end
        end else if (eval_err || timeout_fire) begin
            valid_run_next = '0;
            confirm_next   = '0;
            if (timeout_fire) begin
                signal_ok_next = 1'b0;
                mode_req_next  = 1'b0;
            end
        end
    end

    // Registered outputs and frame counters.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            MODE_REQ     <= 1'b0;
            SIGNAL_OK    <= 1'b0;
            PULSE_WIDTH  <= '0;
            PULSE_STROBE <= 1'b0;
            PULSE_ERR    <= 1'b0;
            valid_run    <= '0;
            confirm_cnt  <= '0;
        end else begin
            PULSE_STROBE <= eval_valid;
            PULSE_ERR    <= eval_err;
            if (eval_valid) PULSE_WIDTH <= width_cnt;
            MODE_REQ     <= mode_req_next;
            SIGNAL_OK    <= signal_ok_next;
            valid_run    <= valid_run_next;
            confirm_cnt  <= confirm_next;
        end
    end

endmodule

// File: tb/tb_rc_pwm_mode_detector.sv
// tb_rc_pwm_mode_detector: randomized and directed frames against a per-frame
// behavioural model of the mode detector (time-scaled parameters).
`timescale 1ns/1ps
module tb_rc_pwm_mode_detector;
    localparam int C    = 3;
    localparam int MIN  = 90;
    localparam int MAX  = 210;
    localparam int ON   = 160;
    localparam int OFF  = 140;
    localparam int CONF = 3;
    localparam int TUS  = 1000;
    localparam int TC   = TUS * C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm = 1'b1;
    logic        mode_req, signal_ok, strobe, err;
    logic [11:0] width;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_strobe = 0;
    int n_err    = 0;

    typedef struct {
        logic        st, er, md, so;
        logic        pre_ev, pre_md, pre_so;
        logic [11:0] w;
        int          at;
    } obs_t;

    // Behavioural model state, updated once per frame.
    bit m_mode, m_sig;
    int m_width, m_run, m_agree, m_last_valid;

    rc_pwm_mode_detector #(
        .CLKS_PER_US(C), .MIN_US(MIN), .MAX_US(MAX), .ON_US(ON),
        .OFF_US(OFF), .CONFIRM(CONF), .TIMEOUT_US(TUS)
    ) dut (
        .CLOCK_50(clk), .RESET(rst), .PWM_IN(pwm),
        .MODE_REQ(mode_req), .SIGNAL_OK(signal_ok), .PULSE_WIDTH(width),
        .PULSE_STROBE(strobe), .PULSE_ERR(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (strobe) n_strobe <= n_strobe + 1;
        if (err)    n_err    <= n_err + 1;
    end

    task automatic model_reset();
        m_mode = 0; m_sig = 0; m_width = 0; m_run = 0; m_agree = 0;
        m_last_valid = cyc;
    endtask

    task automatic model_timeout();
        m_mode = 0; m_sig = 0; m_run = 0; m_agree = 0;
    endtask

    // One frame of high_cycles sampled-high clocks, result visible at cycle 'at'.
    task automatic model_frame(input int hi_cycles, input int at, output bit e_st, output bit e_er);
        int us;
        int want;
        us = hi_cycles / C;
        if (at - m_last_valid > TC) model_timeout();
        if (us < MIN || us > MAX) begin
            e_st = 0; e_er = 1;
            m_run = 0; m_agree = 0;
        end else begin
            e_st = 1; e_er = 0;
            m_width = us;
            m_last_valid = at;
            if (m_run < CONF) m_run++;
            if (m_run >= CONF) m_sig = 1;
            want = (us >= ON) ? 1 : (us <= OFF) ? 0 : -1;
            if (want < 0 || want == int'(m_mode)) begin
                m_agree = 0;
            end else begin
                m_agree++;
                if (m_agree >= CONF) begin
                    m_agree = 0;
                    if (want == 0 || m_sig) m_mode = (want == 1);
                end
            end
        end
    endtask

    // Drive one pulse (hi cycles high, then low) and sample the outcome.
    task automatic drive_pulse(input int hi, input int lo, output obs_t o);
        @(negedge clk);
        pwm = 1'b1;
        repeat (hi) @(negedge clk);
        pwm = 1'b0;
        repeat (3) @(negedge clk);
        o.pre_ev = strobe | err;
        o.pre_md = mode_req;
        o.pre_so = signal_ok;
        @(negedge clk);
        o.st = strobe; o.er = err; o.md = mode_req; o.so = signal_ok; o.w = width;
        o.at = cyc;
        if (lo > 4) repeat (lo - 4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pwm = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({mode_req, signal_ok, strobe, err, width} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: got md=%b ok=%b st=%b er=%b w=%0d, want all 0",
                     mode_req, signal_ok, strobe, err, width);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_first_lock();
        obs_t o;
        bit es, ee, pm, ps;
        logic [18:0] got, want;
        int s0, e0;
        s0 = n_strobe; e0 = n_err;
        repeat (80 * C) @(negedge clk);
        pwm = 1'b0;
        repeat (40) @(negedge clk);
        n_tests++;
        if (n_strobe != s0 || n_err != e0) begin
            n_fail++;
            $display("FAIL partial_pulse: got strobes=%0d errs=%0d, want 0 0", n_strobe - s0, n_err - e0);
        end
        for (int i = 0; i < 3; i++) begin
            pm = m_mode; ps = m_sig;
            drive_pulse(190 * C, 60, o);
            model_frame(190 * C, o.at, es, ee);
            got  = {o.pre_ev, o.pre_md, o.pre_so, o.st, o.er, o.md, o.so, o.w};
            want = {1'b0, pm, ps, es, ee, m_mode, m_sig, 12'(m_width)};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL first_lock[%0d]: got flags %b w=%0d, want flags %b w=%0d",
                         i, got[18:12], got[11:0], want[18:12], want[11:0]);
            end
        end
    endtask

    task automatic test_hysteresis();
        int seq [7] = '{150, 120, 120, 150, 120, 120, 120};
        obs_t o;
        bit es, ee, pm, ps;
        logic [18:0] got, want;
        for (int i = 0; i < 7; i++) begin
            pm = m_mode; ps = m_sig;
            drive_pulse(seq[i] * C, 40, o);
            model_frame(seq[i] * C, o.at, es, ee);
            got  = {o.pre_ev, o.pre_md, o.pre_so, o.st, o.er, o.md, o.so, o.w};
            want = {1'b0, pm, ps, es, ee, m_mode, m_sig, 12'(m_width)};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL hysteresis[%0d]: got flags %b w=%0d, want flags %b w=%0d",
                         i, got[18:12], got[11:0], want[18:12], want[11:0]);
            end
        end
    endtask

    task automatic test_error_restart();
        int seq [6] = '{190, 190, 250, 190, 190, 190};
        obs_t o;
        bit es, ee, pm, ps;
        logic [18:0] got, want;
        for (int i = 0; i < 6; i++) begin
            pm = m_mode; ps = m_sig;
            drive_pulse(seq[i] * C, 40, o);
            model_frame(seq[i] * C, o.at, es, ee);
            got  = {o.pre_ev, o.pre_md, o.pre_so, o.st, o.er, o.md, o.so, o.w};
            want = {1'b0, pm, ps, es, ee, m_mode, m_sig, 12'(m_width)};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL error_restart[%0d]: got flags %b w=%0d, want flags %b w=%0d",
                         i, got[18:12], got[11:0], want[18:12], want[11:0]);
            end
        end
    endtask

    task automatic test_boundaries();
        // High-time in clocks: range edges, floor edges, ON/OFF thresholds.
        int seq [13] = '{267, 633, 270, 630, 269, 632, 420, 420, 420, 423, 480, 480, 480};
        obs_t o;
        bit es, ee, pm, ps;
        logic [18:0] got, want;
        for (int i = 0; i < 13; i++) begin
            pm = m_mode; ps = m_sig;
            drive_pulse(seq[i], 30, o);
            model_frame(seq[i], o.at, es, ee);
            got  = {o.pre_ev, o.pre_md, o.pre_so, o.st, o.er, o.md, o.so, o.w};
            want = {1'b0, pm, ps, es, ee, m_mode, m_sig, 12'(m_width)};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL boundary[%0d] cycles=%0d: got flags %b w=%0d, want flags %b w=%0d",
                         i, seq[i], got[18:12], got[11:0], want[18:12], want[11:0]);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        bit es, ee, seen;
        int t0, t, s0;
        // Pin idles low after the last valid frame.
        t0 = m_last_valid; seen = 0; t = 0;
        for (int i = 0; i < TC + 100 && !seen; i++) begin
            @(negedge clk);
            if (!signal_ok) begin seen = 1; t = cyc; end
        end
        n_tests++;
        if (!seen || t - t0 != TC) begin
            n_fail++;
            $display("FAIL timeout_low: got elapsed=%0d seen=%0d, want %0d", t - t0, seen, TC);
        end
        n_tests++;
        if (mode_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_low_mode: got %b, want 0", mode_req);
        end
        model_timeout();
        for (int i = 0; i < 3; i++) begin
            drive_pulse(190 * C, 40, o);
            model_frame(190 * C, o.at, es, ee);
        end
        n_tests++;
        if ({mode_req, signal_ok} !== {m_mode, m_sig} || m_mode != 1) begin
            n_fail++;
            $display("FAIL timeout_relock: got md=%b ok=%b, want 1 1", mode_req, signal_ok);
        end
        // Pin stuck high.
        t0 = m_last_valid; s0 = n_strobe; seen = 0; t = 0;
        @(negedge clk);
        pwm = 1'b1;
        for (int i = 0; i < TC + 100 && !seen; i++) begin
            @(negedge clk);
            if (!signal_ok) begin seen = 1; t = cyc; end
        end
        n_tests++;
        if (!seen || t - t0 != TC || mode_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_high: got elapsed=%0d seen=%0d md=%b, want %0d 1 0", t - t0, seen, mode_req, TC);
        end
        n_tests++;
        if (n_strobe != s0) begin
            n_fail++;
            $display("FAIL timeout_high_strobe: got %0d strobes, want 0", n_strobe - s0);
        end
        model_timeout();
        pwm = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({err, strobe} !== 2'b10) begin
            n_fail++;
            $display("FAIL stuck_pulse_end: got er=%b st=%b, want 1 0", err, strobe);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset_mid_pulse();
        obs_t o;
        bit es, ee;
        logic [18:0] got, want;
        int s0, e0;
        for (int i = 0; i < 3; i++) begin
            drive_pulse(190 * C, 40, o);
            model_frame(190 * C, o.at, es, ee);
        end
        n_tests++;
        if (mode_req !== 1'b1 || m_mode != 1) begin
            n_fail++;
            $display("FAIL pre_reset_mode: got %b, want 1", mode_req);
        end
        @(negedge clk);
        pwm = 1'b1;
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({mode_req, signal_ok, strobe, err, width} !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: got md=%b ok=%b st=%b er=%b w=%0d, want all 0",
                     mode_req, signal_ok, strobe, err, width);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        s0 = n_strobe; e0 = n_err;
        repeat (150) @(negedge clk);
        pwm = 1'b0;
        repeat (40) @(negedge clk);
        n_tests++;
        if (n_strobe != s0 || n_err != e0) begin
            n_fail++;
            $display("FAIL truncated_pulse: got strobes=%0d errs=%0d, want 0 0", n_strobe - s0, n_err - e0);
        end
        for (int i = 0; i < 3; i++) begin
            drive_pulse(190 * C, 40, o);
            model_frame(190 * C, o.at, es, ee);
            got  = {1'b0, 1'b0, 1'b0, o.st, o.er, o.md, o.so, o.w};
            want = {1'b0, 1'b0, 1'b0, es, ee, m_mode, m_sig, 12'(m_width)};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got flags %b w=%0d, want flags %b w=%0d",
                         i, got[18:12], got[11:0], want[18:12], want[11:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int seq [6] = '{120, 120, 120, 190, 190, 190};
        obs_t o;
        bit es, ee, pm, ps;
        logic [18:0] got, want;
        for (int i = 0; i < 6; i++) begin
            pm = m_mode; ps = m_sig;
            drive_pulse(seq[i] * C, 5, o);
            model_frame(seq[i] * C, o.at, es, ee);
            got  = {o.pre_ev, o.pre_md, o.pre_so, o.st, o.er, o.md, o.so, o.w};
            want = {1'b0, pm, ps, es, ee, m_mode, m_sig, 12'(m_width)};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got flags %b w=%0d, want flags %b w=%0d",
                         i, got[18:12], got[11:0], want[18:12], want[11:0]);
            end
        end
    endtask

    task automatic test_random();
        obs_t o;
        bit es, ee, pm, ps;
        logic [18:0] got, want;
        int us, hi, lo, side, inv_run;
        side = 0; inv_run = 0;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(2, 0) == 0) side = int'($urandom_range(3, 0));
            case (side)
                0:       us = int'($urandom_range(OFF, MIN));
                1:       us = int'($urandom_range(MAX, ON));
                2:       us = int'($urandom_range(ON - 1, OFF + 1));
                default: us = ($urandom_range(1, 0) == 0) ? int'($urandom_range(MIN - 1, 80))
                                                          : int'($urandom_range(230, MAX + 1));
            endcase
            if (inv_run >= 2) us = int'($urandom_range(MAX, MIN));
            hi = us * C + int'($urandom_range(C - 1, 0));
            lo = int'($urandom_range(60, 5));
            if (hi / C < MIN || hi / C > MAX) inv_run++; else inv_run = 0;
            pm = m_mode; ps = m_sig;
            drive_pulse(hi, lo, o);
            model_frame(hi, o.at, es, ee);
            got  = {o.pre_ev, o.pre_md, o.pre_so, o.st, o.er, o.md, o.so, o.w};
            want = {1'b0, pm, ps, es, ee, m_mode, m_sig, 12'(m_width)};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL random[%0d] cycles=%0d: got flags %b w=%0d, want flags %b w=%0d",
                         i, hi, got[18:12], got[11:0], want[18:12], want[11:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_lock();
        test_hysteresis();
        test_error_restart();
        test_boundaries();
        test_timeout();
        test_reset_mid_pulse();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
